// File: rtl/btb_replace_ctrl.sv
// Replacement controller for the IF-stage BTB: per-line valid bits, one outstanding fill, victim selection.
// Optional macro BTB_PLRU_EN selects tree pseudo-LRU; otherwise a round-robin pointer is the policy.
module btb_replace_ctrl #(
  parameter int WIDTH    = 4,
  parameter int LINE_NUM = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                alloc_req,
  output logic                alloc_gnt,
  output logic [WIDTH-1:0]    alloc_index,
  input  logic                commit,
  input  logic                cancel,
  input  logic                hit_valid,
  input  logic [WIDTH-1:0]    hit_index,
  input  logic                inval_all,
  output logic [LINE_NUM-1:0] valid_out,
  output logic                all_valid,
  output logic                busy
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t              state;
  logic [LINE_NUM-1:0] valid;
  logic [WIDTH-1:0]    pend_index;
  logic [WIDTH-1:0]    free_index;
  logic [WIDTH-1:0]    policy_index;
  logic                commit_fire;

  function automatic logic [WIDTH-1:0] first_free(input logic [LINE_NUM-1:0] v);
    logic [WIDTH-1:0] idx;
    idx = '0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (!v[i]) idx = WIDTH'(i);
    end
    return idx;
  endfunction

  // A cancel in the same cycle as a commit drops the fill.
  assign commit_fire = (state == PEND) && commit && !cancel;

  assign free_index  = first_free(valid);
  assign all_valid   = &valid;
  assign valid_out   = valid;
  assign busy        = (state == PEND);
  assign alloc_index = all_valid ? policy_index : free_index;
  assign alloc_gnt   = (state == IDLE) && alloc_req && !inval_all;

`ifdef BTB_PLRU_EN
  // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1; bit 0 selects the lower child.
  logic [LINE_NUM-1:1] plru;
  logic [LINE_NUM-1:1] plru_next;

  function automatic logic [LINE_NUM-1:1] plru_touch(input logic [LINE_NUM-1:1] t,
                                                     input logic [WIDTH-1:0]    line);
    logic [WIDTH:0] node;
    node = {1'b1, line};
    for (int l = 0; l < WIDTH; l++) begin
      t[node[WIDTH:1]] = ~node[0];
      node = {1'b0, node[WIDTH:1]};
    end
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] plru_victim(input logic [LINE_NUM-1:1] t);
    logic [WIDTH:0] node;
    node = {{WIDTH{1'b0}}, 1'b1};
    for (int l = 0; l < WIDTH; l++) begin
      node = {node[WIDTH-1:0], t[node[WIDTH-1:0]]};
    end
    return node[WIDTH-1:0];
  endfunction

  always_comb begin
    plru_next = plru;
    if (hit_valid && valid[hit_index]) plru_next = plru_touch(plru_next, hit_index);
    if (commit_fire)                   plru_next = plru_touch(plru_next, pend_index);
  end

  assign policy_index = plru_victim(plru);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        plru <= '0;
    else if (inval_all) plru <= '0;
    else                plru <= plru_next;
  end
`else
  // Round-robin advances only when a commit replaces a line that was already valid at grant.
  logic [WIDTH-1:0] rr;
  logic             pend_repl;
  logic             unused_hit;

  assign unused_hit   = hit_valid ^ (^hit_index);
  assign policy_index = rr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr        <= '0;
      pend_repl <= 1'b0;
    end else if (inval_all) begin
      rr        <= '0;
      pend_repl <= 1'b0;
    end else begin
      if (alloc_gnt)               pend_repl <= all_valid;
      if (commit_fire && pend_repl) rr       <= rr + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      valid      <= '0;
      pend_index <= '0;
    end else if (inval_all) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (alloc_gnt) begin
            pend_index <= alloc_index;
            state      <= PEND;
          end
        end
        PEND: begin
          if (cancel) begin
            state <= IDLE;
          end else if (commit) begin
            valid[pend_index] <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_replace_ctrl.sv
// Directed self-checking bench for btb_replace_ctrl at WIDTH=2, LINE_NUM=4.
module tb_btb_replace_ctrl;

  localparam int WIDTH    = 2;
  localparam int LINE_NUM = 4;

  logic                clk;
  logic                resetn;
  logic                alloc_req;
  logic                alloc_gnt;
  logic [WIDTH-1:0]    alloc_index;
  logic                commit;
  logic                cancel;
  logic                hit_valid;
  logic [WIDTH-1:0]    hit_index;
  logic                inval_all;
  logic [LINE_NUM-1:0] valid_out;
  logic                all_valid;
  logic                busy;

  int checks;
  int failures;

  btb_replace_ctrl #(.WIDTH(WIDTH), .LINE_NUM(LINE_NUM)) dut (
    .clk(clk), .resetn(resetn),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_index(alloc_index),
    .commit(commit), .cancel(cancel),
    .hit_valid(hit_valid), .hit_index(hit_index),
    .inval_all(inval_all),
    .valid_out(valid_out), .all_valid(all_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant a line, check the chosen index, then commit it.
  task automatic fill(input logic [WIDTH-1:0] exp_idx);
    alloc_req = 1'b1;
    #1;
    chk("fill_gnt", 32'(alloc_gnt), 32'd1);
    chk("fill_idx", 32'(alloc_index), 32'(exp_idx));
    step();
    alloc_req = 1'b0;
    chk("fill_busy", 32'(busy), 32'd1);
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0; alloc_req = 1'b0; commit = 1'b0; cancel = 1'b0;
    hit_valid = 1'b0; hit_index = '0; inval_all = 1'b0;
    step(); step();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_allv", 32'(all_valid), 32'd0);
    chk("rst_gnt", 32'(alloc_gnt), 32'd0);
    resetn = 1'b1;
    step();

    // 1: first fill lands on line 0
    fill(2'd0);
    chk("t1_valid", 32'(valid_out), 32'h1);
    chk("t1_busy", 32'(busy), 32'd0);

    // 3: cancel leaves valid alone, same line offered again
    fill(2'd1);
    chk("t3_valid0", 32'(valid_out), 32'h3);
    alloc_req = 1'b1;
    #1;
    chk("t3_idx", 32'(alloc_index), 32'd2);
    step();
    alloc_req = 1'b0;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("t3_valid1", 32'(valid_out), 32'h3);
    chk("t3_busy", 32'(busy), 32'd0);
    fill(2'd2);
    fill(2'd3);
    chk("t2_valid", 32'(valid_out), 32'hf);
    chk("t2_allv", 32'(all_valid), 32'd1);

    // 2: full BTB, policy victim
    alloc_req = 1'b1;
    #1;
    chk("t2_idx0", 32'(alloc_index), 32'd0);
    step();
    alloc_req = 1'b0;
`ifdef BTB_PLRU_EN
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    hit_valid = 1'b1; hit_index = 2'd0;
    step();
    hit_valid = 1'b0;
    fill(2'd2);
    alloc_req = 1'b1;
    #1;
    chk("t2_plru_idx", 32'(alloc_index), 32'd1);
`else
    commit = 1'b1;
    hit_valid = 1'b1; hit_index = 2'd3;
    step();
    commit = 1'b0; hit_valid = 1'b0;
    alloc_req = 1'b1;
    #1;
    chk("t2_rr_idx", 32'(alloc_index), 32'd1);
`endif
    step();
    alloc_req = 1'b0;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("t2_valid1", 32'(valid_out), 32'hf);

    // 4: no grant while pending nor in the commit cycle
    alloc_req = 1'b1;
    step();
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_gnt_pend", 32'(alloc_gnt), 32'd0);
    commit = 1'b1;
    #1;
    chk("t4_gnt_commit", 32'(alloc_gnt), 32'd0);
    step();
    commit = 1'b0;
    chk("t4_busy_idle", 32'(busy), 32'd0);
    chk("t4_gnt_next", 32'(alloc_gnt), 32'd1);
    step();
    alloc_req = 1'b0;
    chk("t4_busy2", 32'(busy), 32'd1);

    // 5: inval_all beats commit, later commit ignored
    commit = 1'b1; inval_all = 1'b1; alloc_req = 1'b1;
    #1;
    chk("t5_gnt_inval", 32'(alloc_gnt), 32'd0);
    step();
    inval_all = 1'b0; alloc_req = 1'b0;
    chk("t5_valid", 32'(valid_out), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_allv", 32'(all_valid), 32'd0);
    step();
    commit = 1'b0;
    chk("t5_valid2", 32'(valid_out), 32'd0);

    // 6: commit+cancel drops the fill; async reset mid-PEND
    fill(2'd0);
    alloc_req = 1'b1;
    #1;
    chk("t6_idx", 32'(alloc_index), 32'd1);
    step();
    alloc_req = 1'b0;
    commit = 1'b1; cancel = 1'b1;
    step();
    commit = 1'b0; cancel = 1'b0;
    chk("t6_valid", 32'(valid_out), 32'h1);
    chk("t6_busy", 32'(busy), 32'd0);
    alloc_req = 1'b1;
    step();
    chk("t6_busy2", 32'(busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(valid_out), 32'd0);
    chk("t6_rst_gnt", 32'(alloc_gnt), 32'd1);
    chk("t6_rst_idx", 32'(alloc_index), 32'd0);
    alloc_req = 1'b0;
    step();
    resetn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
